cla_add_arbiter: RTL

Shares one combinational carry-lookahead adder among NREQ independent requesters in the posit datapath (fraction alignment, exponent/regime arithmetic). It arbitrates each cycle with a fair round-robin policy, launches the winner's operands through the adder, and registers the unsigned sum plus carry-out with the requester's ID. A valid/ready response port supports backpressure.

---
 rtl/ppu_arb_pkg.sv | 32 +++
 rtl/carry_lookahead_adder.sv | 49 ++++
 rtl/rr_grant.sv | 33 +++
 rtl/cla_add_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/ppu_arb_pkg.sv
// ppu_arb_pkg
//   Shared definitions for posit-unit arbiters.
//   NREQ_MAX : largest requester count any arbiter built on rr_pick supports.
//   rr_pick  : round-robin search over a valid vector, returning {found, index}.
package ppu_arb_pkg;

  localparam int NREQ_MAX = 16;
  localparam int IDX_MAX_W = $clog2(NREQ_MAX);

  // Search starts at ptr and wraps modulo nreq. The first hit in search
  // order wins; bits at or above nreq are never considered.
  function automatic logic [IDX_MAX_W:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                                 input logic [IDX_MAX_W-1:0] ptr,
                                                 input int nreq);
    logic                 found;
    logic [IDX_MAX_W-1:0] idx;
    logic [IDX_MAX_W-1:0] k4;
    int                   k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      k  = (int'(ptr) + i) % nreq;
      k4 = k[IDX_MAX_W-1:0];
      if (!found && (i < nreq) && valid[k4]) begin
        found = 1'b1;
        idx   = k4;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder
//   Unsigned adder built from 4-bit lookahead groups; group carries are
//   produced from group generate/propagate terms.
//   a_i, b_i : operands
//   sum_o    : {carry_out, a_i + b_i}
module carry_lookahead_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  localparam int NG = (WIDTH + 3) / 4;
  localparam int WP = NG * 4;

  logic [WP-1:0] a_p, b_p, g, p, s;
  logic [WP:0]   c;
  logic [NG-1:0] gg, gp;

  always_comb begin
    a_p = WP'(a_i);
    b_p = WP'(b_i);
    g   = a_p & b_p;
    p   = a_p ^ b_p;
    c   = '0;
    gg  = '0;
    gp  = '0;
    for (int grp = 0; grp < NG; grp++) begin
      // Bit carries inside the group come straight from the group carry-in.
      c[grp*4+1] = g[grp*4] | (p[grp*4] & c[grp*4]);
      c[grp*4+2] = g[grp*4+1] | (p[grp*4+1] & g[grp*4])
                 | (p[grp*4+1] & p[grp*4] & c[grp*4]);
      c[grp*4+3] = g[grp*4+2] | (p[grp*4+2] & g[grp*4+1])
                 | (p[grp*4+2] & p[grp*4+1] & g[grp*4])
                 | (p[grp*4+2] & p[grp*4+1] & p[grp*4] & c[grp*4]);
      gg[grp] = g[grp*4+3] | (p[grp*4+3] & g[grp*4+2])
              | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
              | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4]);
      gp[grp] = &p[grp*4 +: 4];
      c[grp*4+4] = gg[grp] | (gp[grp] & c[grp*4]);
    end
    s = p ^ c[WP-1:0];
  end

  // Padding bits are zero, so the carry into bit WIDTH is the true carry-out.
  assign sum_o = {c[WIDTH], s[WIDTH-1:0]};

endmodule

// File: rtl/rr_grant.sv
// rr_grant
//   Combinational round-robin picker.
//   valid_i : request vector, one bit per requester
//   ptr_i   : requester with highest priority this cycle
//   grant_o : one-hot winner (all zero when nothing is valid)
//   idx_o   : winner index
//   found_o : at least one request is valid
module rr_grant
  import ppu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            found_o
);

  logic [NREQ_MAX-1:0]  valid_ext;
  logic [IDX_MAX_W-1:0] ptr_ext;
  logic [IDX_MAX_W:0]   pick;

  assign valid_ext = NREQ_MAX'(valid_i);
  assign ptr_ext   = IDX_MAX_W'(ptr_i);
  assign pick      = rr_pick(valid_ext, ptr_ext, NREQ);

  assign found_o = pick[IDX_MAX_W];
  assign idx_o   = pick[IDW-1:0];
  assign grant_o = found_o ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/cla_add_arbiter.sv
// cla_add_arbiter
//   Round-robin sharing of one carry-lookahead adder among NREQ requesters,
//   with a registered valid/ready response.
//   i_clk, i_rst             : clock, async active-high reset
//   i_req_valid/o_req_ready  : per-requester handshake
//   i_req_add1/i_req_add2    : packed operands, requester k at [k*WIDTH +: WIDTH]
//   o_rsp_valid/i_rsp_ready  : response handshake
//   o_rsp_result             : {carry_out, sum}
//   o_rsp_id                 : requester that issued the result
module cla_add_arbiter
  import ppu_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_add1,
  input  logic [NREQ*WIDTH-1:0] i_req_add2,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH:0]        o_rsp_result,
  output logic [IDW-1:0]        o_rsp_id
);

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [WIDTH:0]  rsp_result_q, rsp_result_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]  pick_onehot;
  logic [IDW-1:0]   pick_idx;
  logic             pick_found;
  logic             can_accept;
  logic             grant;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   add_sum;

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_grant (
    .valid_i (i_req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_onehot),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign can_accept  = !rsp_valid_q || i_rsp_ready;
  assign grant       = can_accept && pick_found;
  assign o_req_ready = can_accept ? pick_onehot : '0;

  assign op_a = i_req_add1[pick_idx*WIDTH +: WIDTH];
  assign op_b = i_req_add2[pick_idx*WIDTH +: WIDTH];

  carry_lookahead_adder #(
    .WIDTH (WIDTH)
  ) u_cla (
    .a_i   (op_a),
    .b_i   (op_b),
    .sum_o (add_sum)
  );

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    if (grant) begin
      rr_ptr_d     = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      rsp_valid_d  = 1'b1;
      rsp_result_d = add_sum;
      rsp_id_d     = pick_idx;
    end else if (i_rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_id     = rsp_id_q;

endmodule
